// File: rtl/periph_bus_fabric.sv
// Memory-mapped peripheral interconnect: registered decode, per-slave ready handshakes,
// core stall and bus-error reporting. Define FABRIC_TIMEOUT_EN to add the hung-slave timeout.
module periph_bus_fabric #(
    parameter int unsigned N_SLAVES   = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SLOT_SHIFT = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  addr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic                         we_i,
    input  logic                         re_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic                         stall_o,
    output logic                         bus_err_o,
    output logic [31:0]                  err_addr_o,
    output logic [N_SLAVES-1:0]          sel_o,
    output logic                         we_o,
    output logic                         re_o,
    output logic [SLOT_SHIFT-1:0]        addr_o,
    output logic [DATA_W-1:0]            wdata_o,
    input  logic [N_SLAVES*DATA_W-1:0]   rdata_i,
    input  logic [N_SLAVES-1:0]          ready_i
);

    if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_n_slaves
        $error("periph_bus_fabric: N_SLAVES must be in 1..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("periph_bus_fabric: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    // Window bounds in 33 bits so a window ending at the top of memory cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(N_SLAVES) << SLOT_SHIFT);

    state_t                state;
    logic                  req;
    logic                  hit;
    logic [3:0]            slot_idx;
    logic [N_SLAVES-1:0]   slot_onehot;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  sel_ready;
    logic                  timeout_hit;

    assign req         = we_i | re_i;
    assign slot_idx    = addr_i[SLOT_SHIFT +: 4];
    assign hit         = ({1'b0, addr_i} >= WIN_LO) && ({1'b0, addr_i} < WIN_HI)
                         && (32'(slot_idx) < N_SLAVES);
    assign slot_onehot = N_SLAVES'(1) << slot_idx;

    // The request term makes stall_o combinational so the core freezes in the request cycle.
    assign stall_o = ((state == IDLE) && req) || (state == ACCESS);

    // Ready bits of unselected slots are masked off here.
    assign sel_ready = |(ready_i & sel_o);

    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_o[k]) sel_rdata |= rdata_i[k*DATA_W +: DATA_W];
        end
    end

`ifdef FABRIC_TIMEOUT_EN
    logic [15:0] timeout_cnt;
    logic [31:0] addr_q;

    assign timeout_hit = ((timeout_cnt + 16'd1) == 16'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_o      <= '0;
            we_o       <= 1'b0;
            re_o       <= 1'b0;
            addr_o     <= '0;
            wdata_o    <= '0;
            rdata_o    <= '0;
            bus_err_o  <= 1'b0;
            err_addr_o <= '0;
`ifdef FABRIC_TIMEOUT_EN
            timeout_cnt <= '0;
            addr_q      <= '0;
`endif
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            state   <= ACCESS;
                            sel_o   <= slot_onehot;
                            we_o    <= we_i;
                            re_o    <= re_i & ~we_i;
                            addr_o  <= addr_i[SLOT_SHIFT-1:0];
                            wdata_o <= wdata_i;
`ifdef FABRIC_TIMEOUT_EN
                            timeout_cnt <= '0;
                            addr_q      <= addr_i;
`endif
                        end else begin
                            state      <= ERR;
                            bus_err_o  <= 1'b1;
                            rdata_o    <= '0;
                            err_addr_o <= addr_i;
                        end
                    end
                end

                ACCESS: begin
                    if (sel_ready) begin
                        if (re_o) rdata_o <= sel_rdata;
                        sel_o <= '0;
                        we_o  <= 1'b0;
                        re_o  <= 1'b0;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        sel_o      <= '0;
                        we_o       <= 1'b0;
                        re_o       <= 1'b0;
                        state      <= ERR;
                        bus_err_o  <= 1'b1;
                        rdata_o    <= '0;
`ifdef FABRIC_TIMEOUT_EN
                        err_addr_o <= addr_q;
`endif
                    end else begin
`ifdef FABRIC_TIMEOUT_EN
                        timeout_cnt <= timeout_cnt + 16'd1;
`endif
                    end
                end

                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/periph_bus_fabric.md
# periph_bus_fabric

Parametrised memory-mapped peripheral interconnect between the unicycle core's data port and N peripheral slots (RAM, UART, LEDs, 7-segment, Gauss filter, switches, and future blocks). It replaces the fixed combinational decoders and read mux with these functions:
- a decoded, registered access path;
- per-slave ready handshakes, so peripherals can insert wait states;
- a stall output that freezes the core while a transfer is in progress;
- bus-error reporting for unmapped addresses and hung slaves.

## Interface
Parameters:
- N_SLAVES, 8, number of peripheral slots (1..16)
- DATA_W, 32, data width
- SLOT_SHIFT, 8, log2 of slot window size in bytes; slot index = addr_i[SLOT_SHIFT +: 4]
- BASE_ADDR, 32'h0000_2000, fabric window base; window = BASE_ADDR .. BASE_ADDR + N_SLAVES·2^SLOT_SHIFT − 1
- TIMEOUT, 255, max ACCESS cycles before error (1..65535)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (10 MHz domain)
- rst  in  1  synchronous active-high reset
- addr_i  in  32  core data address
- wdata_i  in  DATA_W  core write data
- we_i  in  1  core write request
- re_i  in  1  core read request
- rdata_o  out  DATA_W  read data to core
- stall_o  out  1  core must hold request and PC
- bus_err_o  out  1  one-cycle error pulse
- err_addr_o  out  32  address of last errored access
- sel_o  out  N_SLAVES  one-hot slave select
- we_o  out  1  write qualifier, valid while sel_o ≠ 0
- re_o  out  1  read qualifier, valid while sel_o ≠ 0
- addr_o  out  SLOT_SHIFT  offset within slot
- wdata_o  out  DATA_W  registered write data
- rdata_i  in  N_SLAVES·DATA_W  concatenated slave read data (slot k at [k·DATA_W +: DATA_W])
- ready_i  in  N_SLAVES  per-slave completion

## Operation
- States: IDLE, ACCESS, DONE, ERR.
- IDLE, request (we_i|re_i) with in-window address and slot < N_SLAVES:
  - latch addr, wdata and type; set sel_o one-hot; clear timeout counter;
  - go to ACCESS.
- IDLE, request with out-of-window address or slot ≥ N_SLAVES: go to ERR; sel_o stays 0.
- we_i and re_i both high: treated as a write.
- ACCESS: sel_o, we_o/re_o, addr_o and wdata_o are held stable.
  - ready_i[sel] = 1 → capture rdata_i[sel] (reads) into the rdata register; drop sel_o; go to DONE.
  - ready_i bits of unselected slots are ignored.
- DONE: stall_o = 0 for one cycle; rdata_o holds captured data (writes: unchanged). Next state IDLE.
- ERR, for one cycle:
  - stall_o = 0, bus_err_o = 1, rdata_o = 0;
  - err_addr_o ← latched address;
  - next state IDLE.
- stall_o = (IDLE & (we_i|re_i)) | ACCESS. This path is combinational from we_i/re_i.
- The core is expected to hold its request while stalled. After DONE/ERR the core presents its next instruction; a request seen in IDLE is always treated as new.
- Reset mid-transfer: the transfer is dropped, no slave completion is recorded, and all outputs go to their reset values.

## Timing
- Reset values: state IDLE; sel_o = 0, we_o = 0, re_o = 0, addr_o = 0, wdata_o = 0, rdata_o = 0, bus_err_o = 0, err_addr_o = 0, counter = 0. stall_o = 0 unless a request is present.
- Minimum access (slave ready in its first ACCESS cycle): request in cycle 0 → ACCESS cycle 1 → DONE cycle 2. That is 2 stall cycles; rdata_o is valid in cycle 2.
- Each wait cycle from the slave adds one stall cycle.
- Error access: request in cycle 0 → ERR cycle 1; bus_err_o is high in cycle 1 only.
- The timeout counter increments in every ACCESS cycle without ready. When the count reaches TIMEOUT, the next state is ERR and sel_o drops.
- rdata_o is registered and holds its value until the next completed read or an error.

## Configuration
- FABRIC_TIMEOUT_EN defined: timeout counter present. A hung slave forces ERR after TIMEOUT cycles.
- FABRIC_TIMEOUT_EN undefined: no counter; ACCESS waits for ready_i indefinitely. The TIMEOUT parameter is ignored. Unmapped-address errors still apply.

## Test plan
- Read slot 2 at 0x0000_2204 (SLOT_SHIFT = 8), slave 2 ready immediately with 0xCAFE_0001 → sel_o = 0000_0100, addr_o = 0x04, stall_o high for 2 cycles, rdata_o = 0xCAFE_0001 in cycle 2.
- Write 0x0000_00A5 to slot 1, slave 1 delays ready by 3 cycles → stall_o high for 5 cycles; we_o, wdata_o and sel_o stable throughout; rdata_o unchanged.
- Read 0x0000_2800 (slot 8 ≥ N_SLAVES) → bus_err_o pulses in cycle 1, rdata_o = 0, err_addr_o = 0x0000_2800, sel_o never asserted.
- FABRIC_TIMEOUT_EN with TIMEOUT = 4, slave 0 never ready → ERR after 4 ACCESS cycles, bus_err_o pulse, sel_o cleared. Without the macro, stall_o stays high for 100+ cycles.
- rst asserted in the second ACCESS cycle of a delayed read → next cycle IDLE, all outputs at reset values. A subsequent read with rst low completes normally.
- we_i and re_i both high to slot 3, with ready_i = all ones → treated as a write, only sel_o[3] asserted, rdata_o not updated.
